// File: rtl/mips_pkg.sv
// Shared MIPS constants: word width, instruction-memory geometry and loader state encoding.
package mips_pkg;

  localparam int unsigned       WORD_W         = 32;
  localparam int unsigned       IMEM_DEPTH     = 256;
  localparam logic [WORD_W-1:0] IMEM_BASE_ADDR = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_HI,
    ST_HDR_LO,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERROR
  } loader_state_t;

endpackage

// File: rtl/byte_packer.sv
// Packs accepted bytes MSB-first into a 32-bit word and pulses word_valid after the 4th byte.
module byte_packer
  import mips_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              take,
  input  logic [7:0]        data,
  output logic              last_byte,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  logic [1:0]        cnt;
  logic [WORD_W-1:0] shreg;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt        <= '0;
      shreg      <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= take && (cnt == 2'd3);
      if (take) begin
        shreg <= {shreg[WORD_W-9:0], data};
        cnt   <= cnt + 2'd1;
      end
    end
  end

  // The shift register still holds the complete word during the strobe cycle,
  // because the next byte is only shifted in at the end of that cycle.
  assign word      = shreg;
  assign last_byte = (cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: length-prefixed byte stream to sequential big-endian word writes.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader
  import mips_pkg::*;
#(
  parameter int unsigned       DEPTH     = IMEM_DEPTH,
  parameter logic [WORD_W-1:0] BASE_ADDR = IMEM_BASE_ADDR,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [WORD_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  words_loaded
);

  loader_state_t state, state_next;

  logic [7:0]       count_hi;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] hdr_cnt;
  logic             drain;
  logic             xfer;
  logic             start_ok;
  logic             last_word;
  logic             last_byte;
  logic             word_valid;
  logic [WORD_W-1:0] word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  assign xfer      = in_valid && in_ready;
  assign start_ok  = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERROR);
  assign hdr_cnt   = {count_hi, in_data};
  assign last_word = (words_loaded == count - CNT_W'(1));

  byte_packer u_packer (
    .clock      (clock),
    .reset      (reset),
    .clear      (start_ok),
    .take       (xfer && state == ST_DATA),
    .data       (in_data),
    .last_byte  (last_byte),
    .word_valid (word_valid),
    .word       (word)
  );

  assign wr_en   = word_valid && (state == ST_DATA);
  assign wr_data = word;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      count_hi     <= '0;
      count        <= '0;
      wr_addr      <= BASE_ADDR;
      words_loaded <= '0;
      drain        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      state <= state_next;
      if (start_ok) begin
        count_hi     <= '0;
        count        <= '0;
        wr_addr      <= BASE_ADDR;
        words_loaded <= '0;
        drain        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum         <= '0;
`endif
      end else begin
        if (xfer && state == ST_HDR_HI) count_hi <= in_data;
        if (xfer && state == ST_HDR_LO) count    <= hdr_cnt;
        // Stop accepting once the final word is complete so a trailing byte
        // is not swallowed by the packer while the last strobe is pending.
        if (xfer && state == ST_DATA && last_byte && last_word) drain <= 1'b1;
        if (wr_en) begin
          wr_addr      <= wr_addr + WORD_W'(4);
          words_loaded <= words_loaded + CNT_W'(1);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (xfer && state != ST_CSUM) csum <= csum ^ in_data;
`endif
      end
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    cpu_hold   = 1'b1;
    case (state)
      ST_IDLE: begin
        if (start_ok) state_next = ST_HDR_HI;
      end
      ST_HDR_HI: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) state_next = ST_HDR_LO;
      end
      ST_HDR_LO: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) begin
          if (hdr_cnt == '0)
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_next = ST_CSUM;
`else
            state_next = ST_DONE;
`endif
          else if (32'(hdr_cnt) > 32'(DEPTH))
            state_next = ST_ERROR;
          else
            state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        in_ready = !drain;
        busy     = 1'b1;
        if (wr_en && last_word)
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_next = ST_CSUM;
`else
          state_next = ST_DONE;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) state_next = (in_data == csum) ? ST_DONE : ST_ERROR;
      end
`endif
      ST_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
        if (start_ok) state_next = ST_HDR_HI;
      end
      ST_ERROR: begin
        error = 1'b1;
        if (start_ok) state_next = ST_HDR_HI;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; checksum scenarios run when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

  logic        clock = 1'b0;
  logic        reset, start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, wr_en, cpu_hold, busy, done, error;
  logic [31:0] wr_addr, wr_data;
  logic [15:0] words_loaded;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int sc;
  int last_acc;

  logic [31:0] wa[$];
  logic [31:0] wd[$];
  int          wc[$];
  logic [7:0]  stream[$];

  imem_loader #(.DEPTH(256), .BASE_ADDR(32'h0000_0000), .CNT_W(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) begin
    if (wr_en === 1'b1) begin
      wa.push_back(wr_addr);
      wd.push_back(wr_data);
      wc.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic clear_log;
    wa.delete(); wd.delete(); wc.delete();
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    sc = cyc;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int   n;
    logic acc;
    n = 0;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    while (!acc && n < 50) begin
      @(negedge clock);
      acc = in_ready;
      @(posedge clock);
      #1;
      n++;
    end
    last_acc = cyc;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL handshake byte %h not accepted within 50 cycles", b);
    end
  endtask

  task automatic send_stream(input bit add_csum);
    logic [7:0] x;
    x = 8'h00;
    foreach (stream[i]) begin
      send_byte(stream[i]);
      x = x ^ stream[i];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (add_csum) send_byte(x);
`else
    if (add_csum) x = 8'h00;
`endif
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    tick(2);
    reset = 1'b0;
    tick(1);
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL reset_cpu_hold got %b want 1", cpu_hold); end
    checks++; if ({busy, done, error, in_ready, wr_en} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b want 00000", {busy, done, error, in_ready, wr_en}); end
    checks++; if (wr_addr !== 32'h0) begin errors++; $display("FAIL reset_wr_addr got %h want 0", wr_addr); end
    checks++; if (words_loaded !== 16'd0) begin errors++; $display("FAIL reset_words got %0d want 0", words_loaded); end
  endtask

  task automatic test_basic;
    clear_log();
    pulse_start();
    checks++; if ({busy, cpu_hold, in_ready} !== 3'b111) begin errors++; $display("FAIL start_flags got %b want 111", {busy, cpu_hold, in_ready}); end
    stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    send_stream(1'b1);
    tick(3);
    checks++; if (wa.size() !== 2) begin errors++; $display("FAIL basic_nwrites got %0d want 2", wa.size()); end
    if (wa.size() == 2) begin
      checks++; if (wa[0] !== 32'h0 || wd[0] !== 32'h12345678) begin errors++; $display("FAIL basic_w0 got %h/%h want 00000000/12345678", wa[0], wd[0]); end
      checks++; if (wa[1] !== 32'h4 || wd[1] !== 32'h9ABCDEF0) begin errors++; $display("FAIL basic_w1 got %h/%h want 00000004/9abcdef0", wa[1], wd[1]); end
      checks++; if (wc[0] - sc !== 6 || wc[1] - sc !== 10) begin errors++; $display("FAIL basic_timing got %0d/%0d want 6/10", wc[0] - sc, wc[1] - sc); end
    end
    checks++; if ({done, cpu_hold, busy, error} !== 4'b1000) begin errors++; $display("FAIL basic_done got %b want 1000", {done, cpu_hold, busy, error}); end
    checks++; if (words_loaded !== 16'd2) begin errors++; $display("FAIL basic_words got %0d want 2", words_loaded); end
  endtask

  task automatic test_stall;
    clear_log();
    pulse_start();
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
    in_valid = 1'b0;
    tick(2);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(2);
    stream = '{8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    send_stream(1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00 ^ 8'h02 ^ 8'h12 ^ 8'h34 ^ 8'h56 ^ 8'h78 ^ 8'h9A ^ 8'hBC ^ 8'hDE ^ 8'hF0);
    in_valid = 1'b0;
`endif
    tick(3);
    checks++; if (wa.size() !== 2) begin errors++; $display("FAIL stall_nwrites got %0d want 2", wa.size()); end
    if (wa.size() == 2) begin
      checks++; if (wd[0] !== 32'h12345678 || wd[1] !== 32'h9ABCDEF0 || wa[1] !== 32'h4) begin errors++; $display("FAIL stall_data got %h/%h@%h", wd[0], wd[1], wa[1]); end
      checks++; if (wc[0] - sc !== 11 || wc[1] - sc !== 15) begin errors++; $display("FAIL stall_timing got %0d/%0d want 11/15", wc[0] - sc, wc[1] - sc); end
    end
    checks++; if (done !== 1'b1 || words_loaded !== 16'd2) begin errors++; $display("FAIL stall_done got %b/%0d want 1/2", done, words_loaded); end
  endtask

  task automatic test_hdr_overflow;
    clear_log();
    pulse_start();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL restart_clears_done got %b want 0", done); end
    stream = '{8'h01, 8'h01};
    send_stream(1'b0);
    tick(4);
    checks++; if ({error, cpu_hold, busy, done, in_ready} !== 5'b11000) begin errors++; $display("FAIL overflow_flags got %b want 11000", {error, cpu_hold, busy, done, in_ready}); end
    checks++; if (wa.size() !== 0) begin errors++; $display("FAIL overflow_writes got %0d want 0", wa.size()); end
  endtask

  task automatic test_zero_count;
    clear_log();
    pulse_start();
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL restart_clears_error got %b want 0", error); end
    stream = '{8'h00, 8'h00};
    send_stream(1'b1);
    tick(1);
    checks++; if ({done, cpu_hold, error} !== 3'b100) begin errors++; $display("FAIL zero_done got %b want 100", {done, cpu_hold, error}); end
    checks++; if (wa.size() !== 0 || words_loaded !== 16'd0) begin errors++; $display("FAIL zero_writes got %0d/%0d want 0/0", wa.size(), words_loaded); end
  endtask

  task automatic test_reset_mid;
    clear_log();
    pulse_start();
    stream = '{8'h00, 8'h01, 8'hAA, 8'hBB};
    send_stream(1'b0);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    checks++; if ({cpu_hold, busy, in_ready, done, error} !== 5'b10000) begin errors++; $display("FAIL midreset_flags got %b want 10000", {cpu_hold, busy, in_ready, done, error}); end
    tick(4);
    checks++; if (wa.size() !== 0) begin errors++; $display("FAIL midreset_writes got %0d want 0", wa.size()); end
    pulse_start();
    stream = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
    send_stream(1'b1);
    tick(3);
    checks++; if (wa.size() !== 1) begin errors++; $display("FAIL reload_nwrites got %0d want 1", wa.size()); end
    else begin
      checks++; if (wa[0] !== 32'h0 || wd[0] !== 32'hCAFEBABE) begin errors++; $display("FAIL reload_w0 got %h/%h want 00000000/cafebabe", wa[0], wd[0]); end
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL reload_done got %b want 1", done); end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum;
    // 00^01^11^22^33^44 = 45
    clear_log();
    pulse_start();
    stream = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
    send_stream(1'b0);
    tick(2);
    checks++; if ({done, error, cpu_hold} !== 3'b100) begin errors++; $display("FAIL csum_good got %b want 100", {done, error, cpu_hold}); end
    clear_log();
    pulse_start();
    stream = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    send_stream(1'b0);
    tick(2);
    checks++; if ({done, error, cpu_hold} !== 3'b011) begin errors++; $display("FAIL csum_bad got %b want 011", {done, error, cpu_hold}); end
    checks++; if (wa.size() !== 1 || wd[0] !== 32'h11223344) begin errors++; $display("FAIL csum_bad_write got n=%0d want 1 word 11223344", wa.size()); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_hdr_overflow();
    test_zero_count();
    test_reset_mid();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
